// File: rtl/qspi_pkg.sv
// Shared types for the QSPI frame decoder: command codes, header layout and FSM states.
package qspi_pkg;

  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b01;

  // First word of every frame.
  typedef struct packed {
    logic [5:0] addr_lo;
    logic [1:0] cmd;
    logic [7:0] burst;
  } qspi_hdr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_WDATA,
    S_WDRAIN,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_SKIP
  } state_t;

  function automatic logic is_valid_cmd(input logic [1:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr];

  // NOTE: the storage array has no reset; only pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // NOTE: flop updates use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qspi_frame_decoder.sv
// QSPI slave front end: parses host frames into register-bus requests and returns read data.
// Writes are buffered in a FIFO; reads are issued directly with an outstanding-request limit.
module qspi_frame_decoder
  import qspi_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int WFIFO_D = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] qspi_mosi,
  input  logic              qspi_mosi_valid,
  output logic [DATA_W-1:0] qspi_miso,
  output logic              qspi_miso_valid,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wr,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [2:0]        err_flags
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int FW    = ADDR_W + DATA_W;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cmd;
  logic [7:0]        r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_cnt;
  logic [8:0]        r_rsp_cnt;
  logic [OUT_W-1:0]  r_out;
  logic [2:0]        r_err;
  logic [DATA_W-1:0] r_miso;
  logic              r_miso_valid;

  qspi_hdr_t         w_hdr;
  logic              w_last_beat;
  logic [8:0]        w_beats;
  logic              w_wr_phase;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [FW-1:0]     w_fifo_rdata;
  logic              w_overflow;
  logic              w_can_issue;
  logic              w_rd_hs;
  logic              w_rsp_acc;
  logic              w_err_cmd;
  logic              w_err_short;

  assign w_hdr       = qspi_hdr_t'(qspi_mosi[15:0]);
  assign w_last_beat = (r_cnt == {1'b0, r_burst});
  assign w_beats     = {1'b0, r_burst} + 9'd1;
  assign w_wr_phase  = (r_state == S_WDATA) || (r_state == S_WDRAIN);
  assign w_fifo_push = (r_state == S_WDATA) && qspi_mosi_valid;
  assign w_fifo_pop  = w_wr_phase && !w_fifo_empty && req_ready;
  assign w_overflow  = w_fifo_push && w_fifo_full && !w_fifo_pop;
  assign w_can_issue = (r_out < OUT_W'(MAX_OUT));
  assign w_rd_hs     = (r_state == S_RD_ISSUE) && w_can_issue && req_ready;
  // Responses with nothing outstanding are stray and never reach the host.
  assign w_rsp_acc   = rsp_valid && (r_out != '0);

  assign w_err_cmd = (r_state == S_IDLE && qspi_mosi_valid && !is_valid_cmd(w_hdr.cmd))
                  || (qspi_mosi_valid && (r_state == S_WDRAIN || r_state == S_RD_ISSUE
                                          || r_state == S_RD_WAIT));
  assign w_err_short = !qspi_mosi_valid && (r_state == S_HDR2 || r_state == S_WDATA);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (WFIFO_D)
  ) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_wdata ({r_addr, qspi_mosi}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (qspi_mosi_valid) w_next = is_valid_cmd(w_hdr.cmd) ? S_HDR2 : S_SKIP;
      S_SKIP:
        if (!qspi_mosi_valid) w_next = S_IDLE;
      S_HDR2:
        if (!qspi_mosi_valid)    w_next = S_IDLE;
        else if (r_cmd == CMD_WR) w_next = S_WDATA;
        else                      w_next = S_RD_ISSUE;
      S_WDATA:
        if (!qspi_mosi_valid || w_last_beat) w_next = S_WDRAIN;
      S_WDRAIN:
        if (w_fifo_empty) w_next = S_IDLE;
      S_RD_ISSUE:
        if (w_rd_hs && w_last_beat) w_next = S_RD_WAIT;
      S_RD_WAIT:
        if (r_rsp_cnt == w_beats) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    unique case (r_state)
      S_WDATA, S_WDRAIN: begin
        if (!w_fifo_empty) begin
          req_valid             = 1'b1;
          req_wr                = 1'b1;
          {req_addr, req_wdata} = w_fifo_rdata;
        end
      end
      S_RD_ISSUE: begin
        req_valid = w_can_issue;
        req_addr  = r_addr;
      end
      default: ;
    endcase
  end

  assign busy            = (r_state != S_IDLE);
  assign err_flags       = r_err;
  assign qspi_miso       = r_miso;
  assign qspi_miso_valid = r_miso_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_burst   <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_rsp_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (qspi_mosi_valid) begin
            r_cmd     <= w_hdr.cmd;
            r_burst   <= w_hdr.burst;
            r_addr    <= ADDR_W'(w_hdr.addr_lo);
            r_cnt     <= '0;
            r_rsp_cnt <= '0;
          end
        end
        S_HDR2:
          if (qspi_mosi_valid) r_addr[ADDR_W-1:6] <= qspi_mosi[ADDR_W-7:0];
        S_WDATA:
          if (qspi_mosi_valid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
          end
        S_RD_ISSUE:
          if (w_rd_hs) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
          end
        default: ;
      endcase
      if (w_rsp_acc) r_rsp_cnt <= r_rsp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_err        <= '0;
      r_miso       <= '0;
      r_miso_valid <= 1'b0;
    end else begin
      case ({w_rd_hs, w_rsp_acc})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
      r_err        <= r_err | {w_err_cmd, w_err_short, w_overflow};
      r_miso_valid <= w_rsp_acc;
      if (w_rsp_acc) r_miso <= rsp_rdata;
    end
  end

endmodule
